// File: rtl/mem_boot_loader_pkg.sv
// Shared definitions for the UART memory boot loader.
// Holds the frame-parser state enum, the byte count of each frame field and
// the indices of the well-known target memories.
package mem_boot_loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StTarget,
        StAddr,
        StLen,
        StData,
        StCsum,
        StDone,
        StErr
    } loader_state_e;

    // Byte counts of the frame fields: TARGET, ADDR, LEN and CSUM.
    localparam int unsigned TargetBytes = 1;
    localparam int unsigned AddrBytes   = 4;
    localparam int unsigned LenBytes    = 4;
    localparam int unsigned CsumBytes   = 1;

    // Target memory indices.
    localparam int unsigned IMEM = 0;
    localparam int unsigned DMEM = 1;

    // True while a frame is being received, i.e. the CPU must be held.
    function automatic logic frame_active(loader_state_e s);
        return (s == StTarget) || (s == StAddr) || (s == StLen) ||
               (s == StData) || (s == StCsum);
    endfunction

endpackage

// File: rtl/loader_word_pack.sv
// Payload word packer for the boot loader.
// Steers each payload byte into its byte lane, accumulates the byte strobes
// and holds the resulting write until the memory accepts it.
//   clk_i, reset_i        : clock, synchronous active-high reset
//   clear_i               : drop any partial word and pending write (abort)
//   byte_valid_i          : a payload byte is accepted this cycle
//   byte_data_i/addr_i    : the byte and its byte address
//   byte_last_i           : the byte is the last of the payload
//   wready_i              : memory accepts the pending write
//   wr_valid_o            : a write is pending
//   wr_addr_o/data_o/strb_o : word address, data and byte enables of the write
module loader_word_pack #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                                          clk_i,
    input  logic                                          reset_i,
    input  logic                                          clear_i,
    input  logic                                          byte_valid_i,
    input  logic [7:0]                                    byte_data_i,
    input  logic [ADDR_WIDTH-1:0]                         byte_addr_i,
    input  logic                                          byte_last_i,
    input  logic                                          wready_i,
    output logic                                          wr_valid_o,
    output logic [ADDR_WIDTH-$clog2(DATA_WIDTH/8)-1:0]    wr_addr_o,
    output logic [DATA_WIDTH-1:0]                         wr_data_o,
    output logic [DATA_WIDTH/8-1:0]                       wr_strb_o
);

    localparam int unsigned StrbW  = DATA_WIDTH / 8;
    localparam int unsigned LaneW  = $clog2(StrbW);
    localparam int unsigned WordAw = ADDR_WIDTH - LaneW;

    logic              pend_q, pend_d;
    logic [WordAw-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [StrbW-1:0]  strb_q, strb_d;
    logic [LaneW-1:0]  lane;

    assign lane = byte_addr_i[LaneW-1:0];

    always_comb begin
        pend_d = pend_q;
        addr_d = addr_q;
        data_d = data_q;
        strb_d = strb_q;

        // The accepted write leaves first, so a byte arriving in the same
        // cycle starts a fresh word.
        if (pend_q && wready_i) begin
            pend_d = 1'b0;
            data_d = '0;
            strb_d = '0;
        end

        if (byte_valid_i) begin
            data_d[{lane, 3'b000} +: 8] = byte_data_i;
            strb_d[lane]                = 1'b1;
            addr_d                      = byte_addr_i[ADDR_WIDTH-1:LaneW];
            // Flush on the top lane or the end of the payload.
            if ((&lane) || byte_last_i) begin
                pend_d = 1'b1;
            end
        end

        if (clear_i) begin
            pend_d = 1'b0;
            addr_d = '0;
            data_d = '0;
            strb_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pend_q <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            strb_q <= '0;
        end else begin
            pend_q <= pend_d;
            addr_q <= addr_d;
            data_q <= data_d;
            strb_q <= strb_d;
        end
    end

    assign wr_valid_o = pend_q;
    assign wr_addr_o  = addr_q;
    assign wr_data_o  = data_q;
    assign wr_strb_o  = pend_q ? strb_q : '0;

endmodule

// File: rtl/mem_boot_loader.sv
// UART boot loader: parses a load frame from a byte stream and writes its
// payload into one of NUM_MEM target memories while holding the CPU.
// Frame: TARGET(1) ADDR(4, LE) LEN(4, LE) PAYLOAD(LEN) CSUM(1); the 8-bit
// sum of every frame byte including CSUM must be zero.
//   clk, reset           : clock, synchronous active-high reset
//   load_en              : enable; dropping it aborts / acknowledges a frame
//   rx_data/valid/ready  : byte stream from the UART receiver
//   mem_we               : one-hot write strobe per target memory
//   mem_addr/wdata/wstrb : word address, data, byte enables
//   mem_wready           : memory accepts the write
//   cpu_hold             : frame in progress
//   done / error         : frame completed / rejected
module mem_boot_loader
    import mem_boot_loader_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned NUM_MEM    = 2
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        load_en,
    input  logic [7:0]                                  rx_data,
    input  logic                                        rx_valid,
    output logic                                        rx_ready,
    output logic [NUM_MEM-1:0]                          mem_we,
    output logic [ADDR_WIDTH-$clog2(DATA_WIDTH/8)-1:0]  mem_addr,
    output logic [DATA_WIDTH-1:0]                       mem_wdata,
    output logic [DATA_WIDTH/8-1:0]                     mem_wstrb,
    input  logic                                        mem_wready,
    output logic                                        cpu_hold,
    output logic                                        done,
    output logic                                        error
);

    loader_state_e         state_q, state_d;
    logic [1:0]            cnt_q, cnt_d;
    logic [7:0]            target_q, target_d;
    logic [31:0]           addr_q, addr_d;
    // Collects LEN, then counts the payload bytes still to come.
    logic [31:0]           len_q, len_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [7:0]            csum_q, csum_d;
    logic                  cpu_hold_q, cpu_hold_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;

    logic        wr_valid;
    logic        rx_fire;
    logic        pack_valid, pack_last, pack_clear;
    logic [7:0]  csum_next;
    logic [31:0] len_full;
    logic [32:0] frame_end;
    logic [32:0] mem_limit;

    assign rx_ready  = frame_active(state_q) && !(wr_valid && !mem_wready);
    assign rx_fire   = rx_valid && rx_ready;
    assign csum_next = csum_q + rx_data;
    // Complete LEN as seen while its last byte is on the bus.
    assign len_full  = {rx_data, len_q[23:0]};
    assign frame_end = {1'b0, addr_q} + {1'b0, len_full};
    assign mem_limit = 33'd1 << ADDR_WIDTH;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        target_d   = target_q;
        addr_d     = addr_q;
        len_d      = len_q;
        ptr_d      = ptr_q;
        csum_d     = csum_q;
        pack_valid = 1'b0;
        pack_last  = 1'b0;
        pack_clear = 1'b0;

        if (!load_en) begin
            state_d    = StIdle;
            cnt_d      = '0;
            csum_d     = '0;
            pack_clear = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d = StTarget;
                    cnt_d   = '0;
                    csum_d  = '0;
                end
                StTarget: begin
                    if (rx_fire) begin
                        target_d = rx_data;
                        csum_d   = csum_next;
                        cnt_d    = '0;
                        state_d  = StAddr;
                    end
                end
                StAddr: begin
                    if (rx_fire) begin
                        addr_d[{cnt_q, 3'b000} +: 8] = rx_data;
                        csum_d = csum_next;
                        cnt_d  = cnt_q + 2'd1;
                        if (cnt_q == 2'(AddrBytes - 1)) begin
                            cnt_d   = '0;
                            state_d = StLen;
                        end
                    end
                end
                StLen: begin
                    if (rx_fire) begin
                        len_d[{cnt_q, 3'b000} +: 8] = rx_data;
                        csum_d = csum_next;
                        cnt_d  = cnt_q + 2'd1;
                        if (cnt_q == 2'(LenBytes - 1)) begin
                            cnt_d = '0;
                            ptr_d = addr_q[ADDR_WIDTH-1:0];
                            if ((target_q >= 8'(NUM_MEM)) || (frame_end > mem_limit)) begin
                                state_d = StErr;
                            end else if (len_full == 32'd0) begin
                                state_d = StCsum;
                            end else begin
                                state_d = StData;
                            end
                        end
                    end
                end
                StData: begin
                    if (rx_fire) begin
                        pack_valid = 1'b1;
                        pack_last  = (len_q == 32'd1);
                        csum_d     = csum_next;
                        len_d      = len_q - 32'd1;
                        ptr_d      = ptr_q + 1'b1;
                        if (len_q == 32'd1) begin
                            state_d = StCsum;
                        end
                    end
                end
                StCsum: begin
                    // rx_ready already waits for a stalled final write, so
                    // accepting CSUM implies the last write has completed.
                    if (rx_fire) begin
                        csum_d  = csum_next;
                        state_d = (csum_next == 8'd0) ? StDone : StErr;
                    end
                end
                StDone, StErr: begin
                end
                default: state_d = StIdle;
            endcase
        end

        cpu_hold_d = frame_active(state_d);
        done_d     = (state_d == StDone);
        error_d    = (state_d == StErr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            target_q   <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            ptr_q      <= '0;
            csum_q     <= '0;
            cpu_hold_q <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            target_q   <= target_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            ptr_q      <= ptr_d;
            csum_q     <= csum_d;
            cpu_hold_q <= cpu_hold_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    loader_word_pack #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_word_pack (
        .clk_i        (clk),
        .reset_i      (reset),
        .clear_i      (pack_clear),
        .byte_valid_i (pack_valid),
        .byte_data_i  (rx_data),
        .byte_addr_i  (ptr_q),
        .byte_last_i  (pack_last),
        .wready_i     (mem_wready),
        .wr_valid_o   (wr_valid),
        .wr_addr_o    (mem_addr),
        .wr_data_o    (mem_wdata),
        .wr_strb_o    (mem_wstrb)
    );

    // target_q is range-checked before any payload write can be issued.
    assign mem_we   = wr_valid ? (NUM_MEM'(1) << target_q) : '0;
    assign cpu_hold = cpu_hold_q;
    assign done     = done_q;
    assign error    = error_q;

endmodule

// File: tb/tb_mem_boot_loader.sv
module tb_mem_boot_loader;

    localparam int DW  = 32;
    localparam int AW  = 16;
    localparam int NM  = 2;
    localparam int SB  = DW / 8;
    localparam int WAW = AW - 2;

    logic           clk = 1'b0;
    logic           reset;
    logic           load_en;
    logic [7:0]     rx_data;
    logic           rx_valid;
    logic           rx_ready;
    logic [NM-1:0]  mem_we;
    logic [WAW-1:0] mem_addr;
    logic [DW-1:0]  mem_wdata;
    logic [SB-1:0]  mem_wstrb;
    logic           mem_wready;
    logic           cpu_hold;
    logic           done;
    logic           error;

    always #5 clk = ~clk;

    mem_boot_loader #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .NUM_MEM    (NM)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .load_en    (load_en),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_wready (mem_wready),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    typedef struct packed {
        logic [NM-1:0]  we;
        logic [WAW-1:0] addr;
        logic [DW-1:0]  data;
        logic [SB-1:0]  strb;
    } wr_t;

    int   checks = 0;
    int   errors = 0;
    wr_t  obs_q[$];
    wr_t  exp_q[$];
    logic [7:0] pay [64];

    logic prev_stall = 1'b0;
    wr_t  held;
    logic stab_en    = 1'b1;
    int   stall_left = 0;
    logic rand_wr    = 1'b0;
    logic gaps       = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Observe the write port at the negedge, i.e. what the next posedge samples.
    task automatic sample();
        wr_t cur;
        cur = '{we: mem_we, addr: mem_addr, data: mem_wdata, strb: mem_wstrb};
        if (stab_en && prev_stall) check_eq("wr_hold", 64'(cur), 64'(held));
        if (|mem_we && !mem_wready) check_eq("rdy_stall", 64'(rx_ready), 64'd0);
        if (|mem_we && mem_wready) obs_q.push_back(cur);
        prev_stall = stab_en && |mem_we && !mem_wready;
        held = cur;
    endtask

    task automatic drive_wready();
        if (stall_left > 0 && |mem_we) begin
            mem_wready = 1'b0;
            stall_left--;
        end else if (rand_wr) begin
            mem_wready = ($urandom_range(0, 3) != 0);
        end else begin
            mem_wready = 1'b1;
        end
    endtask

    task automatic step(output logic rdy);
        @(negedge clk);
        rdy = rx_ready;
        sample();
        @(posedge clk);
        #1;
        drive_wready();
    endtask

    task automatic tick();
        logic r;
        step(r);
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic rdy;
        int   n;
        if (gaps && $urandom_range(0, 3) == 0) begin
            rx_valid = 1'b0;
            repeat ($urandom_range(1, 3)) tick();
        end
        rx_data  = b;
        rx_valid = 1'b1;
        n = 0;
        do begin
            step(rdy);
            n++;
        end while (!rdy && n < 300);
        if (!rdy) check_eq("rx_accept", 64'(rx_ready), 64'd1);
        rx_valid = 1'b0;
    endtask

    // Reference: group payload bytes by word address; sum of frame bytes is 0.
    task automatic run_frame(input int tgt, input logic [31:0] addr, input int len,
                             input int corrupt, output int base);
        logic [7:0] fr[$];
        logic [7:0] s;
        logic [7:0] cs;
        logic       hdr_ok;
        logic       exp_done;
        wr_t        cur;
        longint unsigned a, w, curw;
        int         ln, n;

        hdr_ok = (tgt < NM) && (longint'(addr) + longint'(len) <= (64'd1 << AW));
        fr.push_back(8'(tgt));
        for (int i = 0; i < 4; i++) fr.push_back(addr[8*i +: 8]);
        for (int i = 0; i < 4; i++) fr.push_back(8'(len >> (8*i)));
        exp_q.delete();
        cur = '0;
        curw = 0;
        if (hdr_ok) begin
            for (int i = 0; i < len; i++) begin
                fr.push_back(pay[i]);
                a  = longint'(addr) + i;
                w  = a / SB;
                ln = int'(a % SB);
                if (i == 0 || w != curw) begin
                    if (i != 0) exp_q.push_back(cur);
                    cur      = '0;
                    cur.we   = NM'(1) << tgt;
                    cur.addr = WAW'(w);
                    curw     = w;
                end
                cur.data[ln*8 +: 8] = pay[i];
                cur.strb[ln]        = 1'b1;
            end
            if (len > 0) exp_q.push_back(cur);
            s = 8'd0;
            foreach (fr[i]) s = s + fr[i];
            cs = 8'd0 - s;
            cs = cs + 8'(corrupt);
            fr.push_back(cs);
        end
        exp_done = hdr_ok && (corrupt == 0);

        base = obs_q.size();
        load_en = 1'b1;
        foreach (fr[i]) send_byte(fr[i]);
        n = 0;
        while (!(done || error) && n < 300) begin
            tick();
            n++;
        end
        check_eq("done", 64'(done), 64'(exp_done));
        check_eq("error", 64'(error), 64'(!exp_done));
        check_eq("hold_end", 64'(cpu_hold), 64'd0);
        check_eq("rdy_end", 64'(rx_ready), 64'd0);
        check_eq("wr_count", 64'(obs_q.size() - base), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && base + i < obs_q.size(); i++) begin
            check_eq("wr_we", 64'(obs_q[base+i].we), 64'(exp_q[i].we));
            check_eq("wr_addr", 64'(obs_q[base+i].addr), 64'(exp_q[i].addr));
            check_eq("wr_data", 64'(obs_q[base+i].data), 64'(exp_q[i].data));
            check_eq("wr_strb", 64'(obs_q[base+i].strb), 64'(exp_q[i].strb));
        end
        load_en = 1'b0;
        tick();
        tick();
        check_eq("idle_flags", 64'({done, error, cpu_hold}), 64'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int base;
        int tgt, len, corrupt;
        logic [31:0] addr;

        reset      = 1'b1;
        load_en    = 1'b0;
        rx_data    = 8'd0;
        rx_valid   = 1'b0;
        mem_wready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ctrl", 64'({rx_ready, cpu_hold, done, error}), 64'd0);
        check_eq("rst_we", 64'(mem_we), 64'd0);
        check_eq("rst_strb", 64'(mem_wstrb), 64'd0);
        check_eq("rst_addr", 64'(mem_addr), 64'd0);
        check_eq("rst_wdata", 64'(mem_wdata), 64'd0);
        reset = 1'b0;
        tick();

        // Aligned imem frame, bytes 01..08.
        for (int i = 0; i < 8; i++) pay[i] = 8'(i + 1);
        run_frame(0, 32'h0, 8, 0, base);
        if (obs_q.size() >= base + 2) begin
            check_eq("d1_data0", 64'(obs_q[base].data), 64'h04030201);
            check_eq("d1_data1", 64'(obs_q[base+1].data), 64'h08070605);
            check_eq("d1_addr1", 64'(obs_q[base+1].addr), 64'd1);
        end

        // Unaligned dmem frame with partial words.
        pay[0] = 8'hAA; pay[1] = 8'hBB; pay[2] = 8'hCC;
        run_frame(1, 32'h6, 3, 0, base);
        if (obs_q.size() >= base + 2) begin
            check_eq("d2_data0", 64'(obs_q[base].data), 64'hBBAA0000);
            check_eq("d2_strb0", 64'(obs_q[base].strb), 64'hC);
            check_eq("d2_data1", 64'(obs_q[base+1].data), 64'h000000CC);
            check_eq("d2_strb1", 64'(obs_q[base+1].strb), 64'h1);
            check_eq("d2_we", 64'(obs_q[base].we), 64'b10);
        end

        // Bad target, bad checksum, zero length, exact top-of-memory fit.
        run_frame(2, 32'h0, 4, 0, base);
        for (int i = 0; i < 5; i++) pay[i] = 8'($urandom);
        run_frame(0, 32'h10, 5, 1, base);
        run_frame(1, 32'h20, 0, 0, base);
        run_frame(0, 32'hFFFC, 4, 0, base);
        run_frame(0, 32'hFFFD, 4, 0, base);

        // First write stalled 5 cycles.
        for (int i = 0; i < 10; i++) pay[i] = 8'($urandom);
        stall_left = 5;
        run_frame(1, 32'h101, 10, 0, base);
        stall_left = 0;

        // Abort mid-payload.
        load_en = 1'b1;
        send_byte(8'h00);
        for (int i = 0; i < 4; i++) send_byte(8'h00);
        send_byte(8'h08);
        for (int i = 0; i < 3; i++) send_byte(8'h00);
        for (int i = 0; i < 3; i++) send_byte(8'(8'h50 + i));
        base = obs_q.size();
        load_en = 1'b0;
        tick();
        check_eq("abort_hold", 64'(cpu_hold), 64'd0);
        check_eq("abort_flags", 64'({done, error, rx_ready}), 64'd0);
        repeat (8) tick();
        check_eq("abort_nowr", 64'(obs_q.size() - base), 64'd0);
        for (int i = 0; i < 8; i++) pay[i] = 8'($urandom);
        run_frame(0, 32'h40, 8, 0, base);

        // Reset while a write is pending and stalled.
        stall_left = 1000;
        load_en = 1'b1;
        send_byte(8'h01);
        for (int i = 0; i < 4; i++) send_byte(8'h00);
        send_byte(8'h08);
        for (int i = 0; i < 3; i++) send_byte(8'h00);
        for (int i = 0; i < 4; i++) send_byte(8'(8'h60 + i));
        tick();
        check_eq("pend_we", 64'(mem_we), 64'b10);
        stab_en = 1'b0;
        base = obs_q.size();
        reset = 1'b1;
        load_en = 1'b0;
        tick();
        reset = 1'b0;
        stall_left = 0;
        check_eq("rst_mid_we", 64'(mem_we), 64'd0);
        check_eq("rst_mid_strb", 64'(mem_wstrb), 64'd0);
        check_eq("rst_mid_hold", 64'(cpu_hold), 64'd0);
        repeat (6) tick();
        check_eq("rst_mid_nowr", 64'(obs_q.size() - base), 64'd0);
        stab_en = 1'b1;
        for (int i = 0; i < 6; i++) pay[i] = 8'($urandom);
        run_frame(1, 32'h3, 6, 0, base);

        // Randomized frames with byte gaps and write back-pressure.
        gaps    = 1'b1;
        rand_wr = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tgt = ($urandom_range(0, 9) == 0) ? int'($urandom_range(2, 7))
                                              : int'($urandom_range(0, NM - 1));
            len = int'($urandom_range(0, 12));
            case ($urandom_range(0, 5))
                0:       addr = 32'h10000 - $urandom_range(0, 8);
                1:       addr = 32'h8000_0000 | $urandom_range(0, 15);
                default: addr = $urandom_range(0, 16'hFFF0);
            endcase
            corrupt = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 255)) : 0;
            for (int i = 0; i < len; i++) pay[i] = 8'($urandom);
            run_frame(tgt, addr, len, corrupt, base);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
